// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: decodes STB/CLK/DIO frames, holds the 16-byte display RAM
// and shifts out the 4 key-scan bytes on read commands.
// Optional build macro: TM1638_PROTOCOL_ERR_EN adds a sticky proto_err output.
module tm1638_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RAM_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        tm_stb,
  input  logic        tm_clk,
  input  logic        tm_dio_in,
  output logic        tm_dio_out,
  output logic        tm_dio_oe,
  input  logic [31:0] key_state,
  input  logic [3:0]  disp_rd_addr,
  output logic [7:0]  disp_rd_data,
  output logic        display_on,
  output logic [2:0]  brightness,
  output logic        frame_strobe
`ifdef TM1638_PROTOCOL_ERR_EN
  ,
  output logic        proto_err
`endif
);

  localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {StIdle, StCmd, StWdata, StRdata, StIgnore} state_e;

  state_e state_q, state_d;

  logic [NS-1:0] stb_sync_q, clk_sync_q, dio_sync_q;
  logic          stb_prev_q, clk_prev_q;
  logic          stb_s, clk_s, dio_s;
  logic          stb_rise, stb_fall, clk_rise, clk_fall;

  logic [7:0]  shift_q;
  logic [2:0]  bitcnt_q;
  logic [3:0]  addr_q;
  logic        fixed_q;
  logic [31:0] keys_q;
  logic [5:0]  rd_idx_q;
  logic        oe_q, dout_q;
  logic        wrote_q;
  logic        disp_on_q;
  logic [2:0]  bright_q;
  logic        fstrobe_q;
  logic [7:0]  rd_data_q;
  logic [7:0]  ram_q [RAM_DEPTH];

  logic [7:0] shift_next;
  logic       byte_done;
  logic       ram_we, cmd_data, cmd_addr, cmd_disp, rd_present, rd_end;

  // Pin synchronisers plus one history flop for edge detection. STB resets to "low" so a
  // frame already in progress at reset release is not mistaken for a new one.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      stb_sync_q <= '0;
      clk_sync_q <= '1;
      dio_sync_q <= '0;
      stb_prev_q <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      stb_sync_q <= {stb_sync_q[NS-2:0], tm_stb};
      clk_sync_q <= {clk_sync_q[NS-2:0], tm_clk};
      dio_sync_q <= {dio_sync_q[NS-2:0], tm_dio_in};
      stb_prev_q <= stb_sync_q[NS-1];
      clk_prev_q <= clk_sync_q[NS-1];
    end
  end

  assign stb_s    = stb_sync_q[NS-1];
  assign clk_s    = clk_sync_q[NS-1];
  assign dio_s    = dio_sync_q[NS-1];
  assign stb_rise = stb_s & ~stb_prev_q;
  assign stb_fall = ~stb_s & stb_prev_q;
  assign clk_rise = clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s & clk_prev_q;

  // LSB-first: the new bit enters at the top, so after 8 rises bit0 sits at [0].
  assign shift_next = {dio_s, shift_q[7:1]};
  assign byte_done  = clk_rise && (bitcnt_q == 3'd7);

  // Next-state and one-cycle control strobes for the datapath.
  always_comb begin
    state_d    = state_q;
    ram_we     = 1'b0;
    cmd_data   = 1'b0;
    cmd_addr   = 1'b0;
    cmd_disp   = 1'b0;
    rd_present = 1'b0;
    rd_end     = 1'b0;
    if (stb_rise) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: if (stb_fall) state_d = StCmd;
        StCmd: begin
          if (byte_done) begin
            case (shift_next[7:6])
              2'b01: begin
                cmd_data = 1'b1;
                state_d  = shift_next[1] ? StRdata : StIgnore;
              end
              2'b11: begin
                cmd_addr = 1'b1;
                state_d  = StWdata;
              end
              2'b10: begin
                cmd_disp = 1'b1;
                state_d  = StIgnore;
              end
              default: state_d = StIgnore;
            endcase
          end
        end
        StWdata: if (byte_done) ram_we = 1'b1;
        StRdata: begin
          if (clk_fall) begin
            if (rd_idx_q == 6'd32) begin
              rd_end  = 1'b1;
              state_d = StIgnore;
            end else begin
              rd_present = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Datapath: bit shifter, command registers, RAM, key read-out and frame strobe.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      shift_q   <= '0;
      bitcnt_q  <= '0;
      addr_q    <= '0;
      fixed_q   <= 1'b0;
      keys_q    <= '0;
      rd_idx_q  <= '0;
      oe_q      <= 1'b0;
      dout_q    <= 1'b0;
      wrote_q   <= 1'b0;
      disp_on_q <= 1'b0;
      bright_q  <= '0;
      fstrobe_q <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= '0;
    end else begin
      fstrobe_q <= stb_rise && wrote_q;
      rd_data_q <= ram_q[disp_rd_addr];

      // Partial bytes are simply dropped when the frame ends.
      if (stb_rise || (state_q == StIdle && stb_fall)) begin
        bitcnt_q <= '0;
        shift_q  <= '0;
        wrote_q  <= 1'b0;
      end else if (clk_rise && state_q != StIdle) begin
        shift_q  <= shift_next;
        bitcnt_q <= bitcnt_q + 3'd1;
      end

      // Read/write is dispatched immediately; only the addressing mode needs to persist.
      if (cmd_data) begin
        fixed_q  <= shift_next[2];
        keys_q   <= key_state;
        rd_idx_q <= '0;
      end
      if (cmd_disp) begin
        disp_on_q <= shift_next[3];
        bright_q  <= shift_next[2:0];
      end
      if (cmd_addr) addr_q <= shift_next[3:0];
      if (ram_we) begin
        ram_q[addr_q] <= shift_next;
        if (!fixed_q) addr_q <= addr_q + 4'd1;
        wrote_q <= 1'b1;
      end

      if (stb_rise || rd_end) begin
        oe_q   <= 1'b0;
        dout_q <= 1'b0;
      end else if (rd_present) begin
        oe_q     <= 1'b1;
        dout_q   <= keys_q[rd_idx_q[4:0]];
        rd_idx_q <= rd_idx_q + 6'd1;
      end
    end
  end

`ifdef TM1638_PROTOCOL_ERR_EN
  logic err_q, err_set;

  // Truncated byte, truncated key read-out, or pad level disagreeing with our own drive.
  assign err_set = (stb_rise && state_q != StIdle && bitcnt_q != 3'd0) ||
                   (stb_rise && state_q == StRdata && !(rd_idx_q == 6'd32 && bitcnt_q == 3'd0)) ||
                   (clk_rise && oe_q && (dio_s != dout_q));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst)        err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign proto_err = err_q;
`endif

  assign tm_dio_out   = dout_q;
  assign tm_dio_oe    = oe_q;
  assign disp_rd_data = rd_data_q;
  assign display_on   = disp_on_q;
  assign brightness   = bright_q;
  assign frame_strobe = fstrobe_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Scoreboard bench for tm1638_responder: stimulus pushes expectations, a monitor observes the
// DUT and compares, and a read-out monitor captures key bytes the way a master would.
module tb_tm1638_responder;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        tm_stb = 1'b1;
  logic        tm_clk = 1'b1;
  logic        m_dio = 1'b1;
  logic        m_oe = 1'b0;
  logic        tm_dio_in;
  logic        tm_dio_out;
  logic        tm_dio_oe;
  logic [31:0] key_state = '0;
  logic [3:0]  disp_rd_addr = '0;
  logic [7:0]  disp_rd_data;
  logic        display_on;
  logic [2:0]  brightness;
  logic        frame_strobe;
`ifdef TM1638_PROTOCOL_ERR_EN
  logic        proto_err;
`endif

  // Open-drain style bus with pull-up; responder drive wins when enabled.
  assign tm_dio_in = tm_dio_oe ? tm_dio_out : (m_oe ? m_dio : 1'b1);

  tm1638_responder #(.SYNC_STAGES(2), .RAM_DEPTH(16)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tm_stb       (tm_stb),
    .tm_clk       (tm_clk),
    .tm_dio_in    (tm_dio_in),
    .tm_dio_out   (tm_dio_out),
    .tm_dio_oe    (tm_dio_oe),
    .key_state    (key_state),
    .disp_rd_addr (disp_rd_addr),
    .disp_rd_data (disp_rd_data),
    .display_on   (display_on),
    .brightness   (brightness),
    .frame_strobe (frame_strobe)
`ifdef TM1638_PROTOCOL_ERR_EN
    ,
    .proto_err    (proto_err)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {KSig, KRam, KByte} kind_e;
  typedef struct {
    kind_e       kind;
    string       name;
    int          sel;
    logic [31:0] val;
  } chk_t;

  localparam int SelOe = 0, SelDout = 1, SelDisp = 2, SelBright = 3, SelFs = 4, SelAddr = 5,
                 SelErr = 6;

  chk_t       exp_q[$];
  logic [7:0] rd_act_q[$];
  int         tests = 0;
  int         fails = 0;
  int         fs_cnt = 0;
  bit         mon_busy = 1'b0;

  always @(posedge clk) if (frame_strobe) fs_cnt <= fs_cnt + 1;

  // Master-side capture of read-out bytes on tm_clk rising edges.
  logic [7:0] rd_sh = '0;
  int         rd_n = 0;
  always @(posedge tm_clk or negedge tm_stb) begin
    if (!tm_stb && !tm_clk) begin
      rd_n <= 0;
    end else if (!tm_stb && tm_dio_oe) begin
      rd_sh <= {tm_dio_in, rd_sh[7:1]};
      if (rd_n == 7) begin
        rd_act_q.push_back({tm_dio_in, rd_sh[7:1]});
        rd_n <= 0;
      end else begin
        rd_n <= rd_n + 1;
      end
    end
  end

  function automatic logic [31:0] sig_val(input int sel);
    case (sel)
      SelOe:     return {31'd0, tm_dio_oe};
      SelDout:   return {31'd0, tm_dio_out};
      SelDisp:   return {31'd0, display_on};
      SelBright: return {29'd0, brightness};
      SelFs:     return fs_cnt;
      SelAddr:   return {28'd0, dut.addr_q};
`ifdef TM1638_PROTOCOL_ERR_EN
      SelErr:    return {31'd0, proto_err};
`endif
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Checking monitor: pops each expectation, observes the DUT, compares.
  initial begin
    chk_t        e;
    logic [31:0] act;
    forever begin
      wait (exp_q.size() != 0);
      mon_busy = 1'b1;
      e = exp_q.pop_front();
      act = 32'hFFFF_FFFF;
      case (e.kind)
        KSig: act = sig_val(e.sel);
        KRam: begin
          disp_rd_addr = e.sel[3:0];
          @(negedge clk);
          @(negedge clk);
          act = {24'd0, disp_rd_data};
        end
        default: begin
          for (int i = 0; i < 400 && rd_act_q.size() == 0; i++) @(negedge clk);
          if (rd_act_q.size() != 0) act = {24'd0, rd_act_q.pop_front()};
        end
      endcase
      tests++;
      if (act !== e.val) begin
        fails++;
        $display("FAIL %s: got %0h want %0h", e.name, act, e.val);
      end
      mon_busy = 1'b0;
    end
  end

  task automatic exp_sig(input string name, input int sel, input logic [31:0] val);
    chk_t e;
    e.kind = KSig; e.name = name; e.sel = sel; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic exp_ram(input string name, input int a, input logic [7:0] val);
    chk_t e;
    e.kind = KRam; e.name = name; e.sel = a; e.val = {24'd0, val};
    exp_q.push_back(e);
  endtask

  task automatic exp_byte(input string name, input logic [7:0] val);
    chk_t e;
    e.kind = KByte; e.name = name; e.sel = 0; e.val = {24'd0, val};
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !mon_busy) return;
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL drain: got %0d pending want 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic frame_start();
    @(negedge clk);
    tm_stb = 1'b0;
    m_oe = 1'b1;
    #160;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tm_clk = 1'b0;
      m_dio = b[i];
      #80;
      tm_clk = 1'b1;
      #80;
    end
  endtask

  task automatic frame_end();
    #80;
    tm_stb = 1'b1;
    m_oe = 1'b0;
    m_dio = 1'b1;
    #320;
  endtask

  task automatic cmd1(input logic [7:0] b);
    frame_start();
    send_bits(b, 8);
    frame_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #33;
    n_rst = 1'b0;
    #50;
    exp_sig("rst_oe", SelOe, 0);
    exp_sig("rst_dout", SelDout, 0);
    exp_sig("rst_disp", SelDisp, 0);
    exp_sig("rst_bright", SelBright, 0);
    exp_sig("rst_fs", SelFs, 0);
    exp_sig("rst_addr", SelAddr, 0);
    exp_ram("rst_ram0", 0, 8'h00);
    exp_ram("rst_ram15", 15, 8'h00);
    drain();

    // Auto-increment burst from address 0.
    cmd1(8'h40);
    frame_start();
    send_bits(8'hC0, 8);
    send_bits(8'h3F, 8);
    send_bits(8'h06, 8);
    send_bits(8'h5B, 8);
    frame_end();
    exp_ram("wr_ram0", 0, 8'h3F);
    exp_ram("wr_ram1", 1, 8'h06);
    exp_ram("wr_ram2", 2, 8'h5B);
    exp_sig("wr_addr", SelAddr, 3);
    exp_sig("wr_fs", SelFs, 1);
    drain();

    // Fixed address: both bytes land at 15.
    cmd1(8'h44);
    frame_start();
    send_bits(8'hCF, 8);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    frame_end();
    exp_ram("fix_ram15", 15, 8'h22);
    exp_ram("fix_ram0", 0, 8'h3F);
    exp_sig("fix_addr", SelAddr, 15);
    exp_sig("fix_fs", SelFs, 2);
    drain();

    // Auto-increment wrap 15 -> 0.
    cmd1(8'h40);
    frame_start();
    send_bits(8'hCF, 8);
    send_bits(8'hAA, 8);
    send_bits(8'hBB, 8);
    frame_end();
    exp_ram("wrap_ram15", 15, 8'hAA);
    exp_ram("wrap_ram0", 0, 8'hBB);
    exp_sig("wrap_addr", SelAddr, 1);
    exp_sig("wrap_fs", SelFs, 3);
    drain();

    // Display control, no frame strobe.
    cmd1(8'h8C);
    exp_sig("dc_on", SelDisp, 1);
    exp_sig("dc_bright4", SelBright, 4);
    exp_sig("dc_fs", SelFs, 3);
    drain();
    cmd1(8'h80);
    exp_sig("dc_off", SelDisp, 0);
    exp_sig("dc_bright0", SelBright, 0);
    exp_sig("dc_fs2", SelFs, 3);
    drain();

    // Key read-out; key_state changes after the command must not be seen.
    key_state = 32'h8001_4002;
    frame_start();
    send_bits(8'h42, 8);
    m_oe = 1'b0;
    key_state = 32'h0;
    exp_byte("rd_b0", 8'h02);
    exp_byte("rd_b1", 8'h40);
    exp_byte("rd_b2", 8'h01);
    exp_byte("rd_b3", 8'h80);
    for (int i = 0; i < 32; i++) begin
      tm_clk = 1'b0;
      #80;
      tm_clk = 1'b1;
      #80;
    end
    exp_sig("rd_oe_bit31", SelOe, 1);
    drain();
    tm_clk = 1'b0;
    #80;
    exp_sig("rd_oe_after32", SelOe, 0);
    drain();
    tm_stb = 1'b1;
    #80;
    tm_clk = 1'b1;
    #240;
    exp_sig("rd_oe_stb", SelOe, 0);
    exp_sig("rd_fs", SelFs, 3);
`ifdef TM1638_PROTOCOL_ERR_EN
    exp_sig("rd_no_err", SelErr, 0);
`endif
    drain();

    // Truncated data byte is discarded.
    cmd1(8'h40);
    frame_start();
    send_bits(8'hC5, 8);
    send_bits(8'h77, 8);
    send_bits(8'h99, 5);
    frame_end();
    exp_ram("part_ram5", 5, 8'h77);
    exp_ram("part_ram6", 6, 8'h00);
    exp_sig("part_addr", SelAddr, 6);
    exp_sig("part_fs", SelFs, 4);
`ifdef TM1638_PROTOCOL_ERR_EN
    exp_sig("part_err", SelErr, 1);
`endif
    drain();

    // Reset in the middle of a key read-out.
    frame_start();
    send_bits(8'h42, 8);
    m_oe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tm_clk = 1'b0;
      #80;
      tm_clk = 1'b1;
      #80;
    end
    tm_clk = 1'b0;
    #40;
    exp_sig("mid_oe_pre", SelOe, 1);
    drain();
    n_rst = 1'b1;
    #1;
    exp_sig("mid_oe_rst", SelOe, 0);
    drain();
    #30;
    n_rst = 1'b0;
    #9;
    tm_clk = 1'b1;
    #80;
    for (int i = 0; i < 6; i++) begin
      tm_clk = 1'b0;
      #80;
      tm_clk = 1'b1;
      #80;
    end
    tm_stb = 1'b1;
    #320;
    rd_act_q.delete();
    exp_ram("mid_ram5", 5, 8'h00);
    exp_ram("mid_ram0", 0, 8'h00);
    exp_sig("mid_addr", SelAddr, 0);
    exp_sig("mid_oe_idle", SelOe, 0);
    exp_sig("mid_fs", SelFs, 4);
`ifdef TM1638_PROTOCOL_ERR_EN
    exp_sig("mid_err", SelErr, 0);
`endif
    drain();

    // Next full frame decodes normally (mode back to write/auto-inc).
    frame_start();
    send_bits(8'hC0, 8);
    send_bits(8'h5A, 8);
    frame_end();
    exp_ram("post_ram0", 0, 8'h5A);
    exp_sig("post_addr", SelAddr, 1);
    exp_sig("post_fs", SelFs, 5);
    drain();

    tests++;
    if (rd_act_q.size() != 0) begin
      fails++;
      $display("FAIL stray_bytes: got %0d want 0", rd_act_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
